// File: rtl/scoreboard_pkg.sv
// Shared constants, state and counter types for the register-hazard scoreboard.
package scoreboard_pkg;

  localparam int NUM_REGS  = 33;
  localparam int REG_IDX_W = 6;
  localparam int CNT_W     = 2;
  localparam int NUM_SRC   = 3;

  typedef logic [CNT_W-1:0] sb_cnt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_t;

  // Indices past the last tracked register are never busy and never counted.
  function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx);
    return (idx < REG_IDX_W'(NUM_REGS));
  endfunction

endpackage

// File: rtl/sb_counter_cell.sv
// Pending-writer counter for one architectural register.
// SCOREBOARD_WB_BYPASS_EN: a last pending writer retiring this cycle no longer blocks readers.
module sb_counter_cell
  import scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic src_ok_o,
  output logic full_o,
  output logic busy_next_o
);

  sb_cnt_t cnt_q;
  sb_cnt_t cnt_d;
  logic    dec_eff_s;

  // Stale writebacks to an idle register are dropped; inc+dec cancel.
  always_comb begin
    cnt_d     = cnt_q;
    dec_eff_s = dec_i && (cnt_q != {CNT_W{1'b0}});
    if (inc_i && !dec_eff_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc_i && dec_eff_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o      = (cnt_q == {CNT_W{1'b1}});
  assign busy_next_o = (cnt_d != {CNT_W{1'b0}});

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign src_ok_o = (cnt_q == {CNT_W{1'b0}}) || ((cnt_q == CNT_W'(1)) && dec_i);
`else
  assign src_ok_o = (cnt_q == {CNT_W{1'b0}});
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard with per-register writer counters and drain handshake.
// SCOREBOARD_WB_BYPASS_EN (see sb_counter_cell) lets a dependent uop issue in its producer's writeback cycle.
module reg_scoreboard
  import scoreboard_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         iss_valid,
  input  logic [NUM_SRC-1:0]           iss_src_vld,
  input  logic [NUM_SRC*REG_IDX_W-1:0] iss_src,
  input  logic [1:0]                   iss_dst_vld,
  input  logic [REG_IDX_W-1:0]         iss_dst0,
  input  logic [REG_IDX_W-1:0]         iss_dst1,
  output logic                         iss_grant,
  input  logic [1:0]                   wb_vld,
  input  logic [REG_IDX_W-1:0]         wb_reg0,
  input  logic [REG_IDX_W-1:0]         wb_reg1,
  input  logic                         drain_req,
  output logic                         drained,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic [31:0]                  stall_cycles
);

  logic [NUM_REGS-1:0]  inc_s;
  logic [NUM_REGS-1:0]  dec_s;
  logic [NUM_REGS-1:0]  src_ok_s;
  logic [NUM_REGS-1:0]  full_s;
  logic [NUM_REGS-1:0]  busy_next_s;
  logic [REG_IDX_W-1:0] src_idx_s;
  logic                 src_blk_s;
  logic                 dst_blk_s;
  logic                 all_zero_next_s;

  sb_state_t     state_q,     state_d;
  logic          drained_q,   drained_d;
  logic [NUM_REGS-1:0] busy_mask_q;
  logic [31:0]   stall_q,     stall_d;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
    assign inc_s[r] = iss_grant &&
                      ((iss_dst_vld[0] && (iss_dst0 == REG_IDX_W'(r))) ||
                       (iss_dst_vld[1] && (iss_dst1 == REG_IDX_W'(r))));
    assign dec_s[r] = (wb_vld[0] && (wb_reg0 == REG_IDX_W'(r))) ||
                      (wb_vld[1] && (wb_reg1 == REG_IDX_W'(r)));

    sb_counter_cell u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc_i       (inc_s[r]),
      .dec_i       (dec_s[r]),
      .src_ok_o    (src_ok_s[r]),
      .full_o      (full_s[r]),
      .busy_next_o (busy_next_s[r])
    );
  end

  // Any valid in-range source still waiting on a writer blocks issue.
  always_comb begin
    src_blk_s = 1'b0;
    src_idx_s = {REG_IDX_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      src_idx_s = iss_src[i*REG_IDX_W +: REG_IDX_W];
      if (iss_src_vld[i] && idx_in_range(src_idx_s) && !src_ok_s[src_idx_s]) begin
        src_blk_s = 1'b1;
      end else begin
        src_blk_s = src_blk_s;
      end
    end
  end

  assign dst_blk_s = (iss_dst_vld[0] && idx_in_range(iss_dst0) && full_s[iss_dst0]) ||
                     (iss_dst_vld[1] && idx_in_range(iss_dst1) && full_s[iss_dst1]);

  assign iss_grant = reset_n && iss_valid && (state_q == RUN) && !drain_req &&
                     !src_blk_s && !dst_blk_s;

  assign all_zero_next_s = ~|busy_next_s;

  // Drain handshake sequencing and stall accounting.
  always_comb begin
    state_d   = state_q;
    drained_d = 1'b0;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
        else           state_d = RUN;
      end
      DRAIN: begin
        if (all_zero_next_s) begin
          state_d   = DONE;
          drained_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (!drain_req) state_d = RUN;
        else            state_d = DONE;
      end
      default: state_d = RUN;
    endcase

    if (iss_valid && !iss_grant && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      drained_q   <= 1'b0;
      busy_mask_q <= {NUM_REGS{1'b0}};
      stall_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      drained_q   <= drained_d;
      busy_mask_q <= busy_next_s;
      stall_q     <= stall_d;
    end
  end

  assign drained      = drained_q;
  assign busy_mask    = busy_mask_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-register pending-count reference model.
module tb_reg_scoreboard;

  localparam int NR = 33;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [2:0]  iss_src_vld = 3'b000;
  logic [17:0] iss_src = 18'd0;
  logic [1:0]  iss_dst_vld = 2'b00;
  logic [5:0]  iss_dst0 = 6'd0, iss_dst1 = 6'd0;
  logic        iss_grant;
  logic [1:0]  wb_vld = 2'b00;
  logic [5:0]  wb_reg0 = 6'd0, wb_reg1 = 6'd0;
  logic        drain_req = 1'b0;
  logic        drained;
  logic [NR-1:0] busy_mask;
  logic [31:0] stall_cycles;

  reg_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid), .iss_src_vld(iss_src_vld),
    .iss_src(iss_src), .iss_dst_vld(iss_dst_vld), .iss_dst0(iss_dst0), .iss_dst1(iss_dst1),
    .iss_grant(iss_grant), .wb_vld(wb_vld), .wb_reg0(wb_reg0), .wb_reg1(wb_reg1),
    .drain_req(drain_req), .drained(drained), .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          mcnt [NR];
  int          mst = M_RUN;
  bit          mdrained = 1'b0;
  int unsigned mstall = 0;
  bit          last_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hits(input logic [1:0] v, input logic [5:0] a, input logic [5:0] b, input int r);
    return (v[0] && (int'(a) == r)) || (v[1] && (int'(b) == r));
  endfunction

  function automatic bit model_grant();
    bit ok;
    ok = iss_valid && (mst == M_RUN) && !drain_req;
    for (int i = 0; i < 3; i++) begin
      int idx;
      bit byp;
      idx = int'(iss_src[i*6 +: 6]);
      byp = 1'b0;
      if (iss_src_vld[i] && idx < NR && mcnt[idx] != 0) begin
        if (BYP && mcnt[idx] == 1 && hits(wb_vld, wb_reg0, wb_reg1, idx)) byp = 1'b1;
        if (!byp) ok = 1'b0;
      end
    end
    if (iss_dst_vld[0] && int'(iss_dst0) < NR && mcnt[iss_dst0] == 3) ok = 1'b0;
    if (iss_dst_vld[1] && int'(iss_dst1) < NR && mcnt[iss_dst1] == 3) ok = 1'b0;
    return ok;
  endfunction

  // Per-cycle comparison against the model, then advance the model across the coming edge.
  initial begin
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_grant", iss_grant, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_drained", drained, 0);
        chk("rst_stall", stall_cycles, 0);
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        mst = M_RUN; mdrained = 1'b0; mstall = 0;
      end else begin
        bit eg;
        bit all0;
        logic [NR-1:0] mmask;
        eg = model_grant();
        for (int r = 0; r < NR; r++) mmask[r] = (mcnt[r] != 0);
        chk("grant", iss_grant, eg);
        chk("busy_mask", busy_mask, mmask);
        chk("drained", drained, mdrained);
        chk("stall_cycles", stall_cycles, mstall);
        all0 = 1'b1;
        for (int r = 0; r < NR; r++) begin
          int inc, dec;
          inc = (eg && hits(iss_dst_vld, iss_dst0, iss_dst1, r)) ? 1 : 0;
          dec = (hits(wb_vld, wb_reg0, wb_reg1, r) && mcnt[r] > 0) ? 1 : 0;
          mcnt[r] = mcnt[r] + inc - dec;
          if (mcnt[r] != 0) all0 = 1'b0;
        end
        if (iss_valid && !eg && mstall != 32'hFFFF_FFFF) mstall++;
        mdrained = 1'b0;
        if (mst == M_RUN) begin
          if (drain_req) mst = M_DRAIN;
        end else if (mst == M_DRAIN) begin
          if (all0) begin mst = M_DONE; mdrained = 1'b1; end
        end else begin
          if (!drain_req) mst = M_RUN;
        end
      end
    end
  end

  // One cycle of stimulus; returns at posedge+1 with the grant seen mid-cycle.
  task automatic step(input bit v, input logic [2:0] sv, input int s0, input int s1, input int s2,
                      input logic [1:0] dv, input int d0, input int d1,
                      input logic [1:0] wv, input int w0, input int w1, input bit dr);
    iss_valid = v; iss_src_vld = sv; iss_src = {6'(s2), 6'(s1), 6'(s0)};
    iss_dst_vld = dv; iss_dst0 = 6'(d0); iss_dst1 = 6'(d1);
    wb_vld = wv; wb_reg0 = 6'(w0); wb_reg1 = 6'(w1); drain_req = dr;
    @(negedge clk);
    #1 last_grant = iss_grant;
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int r);
    step(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, r, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("init_busy", busy_mask, 0);
    chk("init_stall", stall_cycles, 0);

    // RAW hazard on r3
    step(1, 3'b011, 1, 2, 0, 2'b01, 3, 0, 2'b00, 0, 0, 0);
    chk("raw_first_grant", last_grant, 1);
    chk("raw_busy_r3", busy_mask, 33'h8);
    step(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("raw_stall_grant", last_grant, 0);
    chk("raw_stall_cnt1", stall_cycles, 1);
    step(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("raw_stall_cnt2", stall_cycles, 2);
    step(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b01, 3, 0, 0);
    chk("raw_wb_cycle_grant", last_grant, BYP);
    chk("raw_cleared", busy_mask, 0);
    step(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("raw_after_wb_grant", last_grant, 1);
    chk("raw_stall_total", stall_cycles, BYP ? 2 : 3);

    // WAW up to counter max on r5
    for (int k = 0; k < 3; k++) begin
      step(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
      chk("waw_grant", last_grant, 1);
    end
    chk("waw_busy_r5", busy_mask, 33'h20);
    step(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
    chk("waw_full_stall", last_grant, 0);
    step(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b01, 5, 0, 0);
    chk("waw_full_wb_stall", last_grant, 0);
    step(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
    chk("waw_fourth_grant", last_grant, 1);
    step(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
    chk("waw_full_again", last_grant, 0);
    for (int k = 0; k < 3; k++) wb(5);
    chk("waw_drained_r5", busy_mask, 0);

    // Same-cycle inc and dec on r7
    step(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b00, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b01, 7, 0, 0);
    chk("incdec_grant", last_grant, 1);
    chk("incdec_busy_r7", busy_mask, 33'h80);
    wb(7);
    chk("incdec_single_wb_clears", busy_mask, 0);

    // Duplicate dst / duplicate wb on r4, stale wb on r9
    step(1, 3'b000, 0, 0, 0, 2'b11, 4, 4, 2'b00, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 4, 4, 0);
    chk("dupwb_busy_r4", busy_mask, 33'h10);
    wb(4);
    chk("dupwb_cleared", busy_mask, 0);
    wb(9);
    chk("stale_wb_busy", busy_mask, 0);
    step(1, 3'b001, 9, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("no_underflow_grant", last_grant, 1);

    // Drain handshake with r2 pending
    step(1, 3'b000, 0, 0, 0, 2'b01, 2, 0, 2'b00, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    chk("drain_req_blocks", last_grant, 0);
    chk("drain_not_yet", drained, 0);
    step(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2, 0, 1);
    chk("drain_wb_grant", last_grant, 0);
    chk("drained_pulse", drained, 1);
    step(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    chk("drain_hold_grant", last_grant, 0);
    chk("drained_one_cycle", drained, 0);
    step(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("done_release_grant", last_grant, 0);
    step(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    chk("run_again_grant", last_grant, 1);

    // Asynchronous reset mid-drain
    step(1, 3'b000, 0, 0, 0, 2'b01, 10, 0, 2'b00, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 2'b01, 10, 0, 2'b00, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    #2;
    iss_valid = 1'b1; iss_dst_vld = 2'b00; drain_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_grant", iss_grant, 0);
    chk("async_rst_busy", busy_mask, 0);
    chk("async_rst_drained", drained, 0);
    chk("async_rst_stall", stall_cycles, 0);
    iss_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step(1, 3'b001, 10, 0, 0, 2'b01, 11, 0, 2'b00, 0, 0, 0);
    chk("post_rst_grant", last_grant, 1);
    chk("post_rst_busy", busy_mask, 33'h800);

    step(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
